frame_scheduler: RTL and testbench

Sequences the per-frame game-logic update tasks of FlappyBlock against the VGA raster so that game state only changes while the display is blanked. It watches the `y` line counter from `vga_display`. On entry to vertical blanking it issues one start pulse to each update task in order (input sample, physics, collision, score by default) and waits for each task's done handshake before starting the next. A deadline line aborts a sequence that would spill into active video.

---
 rtl/frame_scheduler.sv | 126 ++++++++++++
 tb/tb_frame_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scheduler.sv
// Issues the per-frame game update tasks one after another during vertical blanking.
// Define FRAME_SCHED_WATCHDOG_EN to abort unfinished sequences on DEADLINE_LINE.
`timescale 1ns/1ps

module frame_scheduler #(
   parameter int N_TASKS       = 4,
   parameter int V_ACTIVE      = 480,
   parameter int DEADLINE_LINE = 520
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [9:0]                                   y,
   input  logic                                         pause,
   input  logic [N_TASKS-1:0]                           task_done,
   output logic [N_TASKS-1:0]                           task_start,
   output logic                                         busy,
   output logic [(N_TASKS > 1 ? $clog2(N_TASKS) : 1)-1:0] task_idx,
   output logic [15:0]                                  frame_cnt,
   output logic                                         overrun,
   output logic [7:0]                                   overrun_cnt
);

   localparam int IW = (N_TASKS > 1) ? $clog2(N_TASKS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_TASKS - 1);
   localparam logic [9:0] VB_LINE = 10'(V_ACTIVE);

   if (!((V_ACTIVE < DEADLINE_LINE) && (DEADLINE_LINE < 525))) begin : g_bad_deadline
      $error("frame_scheduler: DEADLINE_LINE must lie strictly between V_ACTIVE and 525");
   end

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   state_t     state;
   logic [9:0] y_q;
   logic       vb_start;

   // Fires only on the first cycle y shows the blanking line, so once per frame.
   always_comb begin
      vb_start = (y == VB_LINE) && (y_q != VB_LINE);
   end

`ifdef FRAME_SCHED_WATCHDOG_EN
   localparam logic [9:0] DL_LINE = 10'(DEADLINE_LINE);
   logic deadline_hit;

   always_comb begin
      deadline_hit = (y == DL_LINE) && (state != IDLE);
   end
`else
   assign overrun     = 1'b0;
   assign overrun_cnt = 8'd0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         y_q         <= 10'd0;
         task_start  <= '0;
         busy        <= 1'b0;
         task_idx    <= '0;
         frame_cnt   <= 16'd0;
`ifdef FRAME_SCHED_WATCHDOG_EN
         overrun     <= 1'b0;
         overrun_cnt <= 8'd0;
`endif
      end else begin
         y_q        <= y;
         task_start <= '0;
         if (vb_start) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
`ifdef FRAME_SCHED_WATCHDOG_EN
         overrun <= 1'b0;
         // The abort outranks any done strobe arriving in the same cycle.
         if (deadline_hit) begin
            state    <= IDLE;
            busy     <= 1'b0;
            task_idx <= '0;
            overrun  <= 1'b1;
            if (overrun_cnt != 8'hFF) begin
               overrun_cnt <= overrun_cnt + 8'd1;
            end
         end else begin
`else
         begin
`endif
            case (state)
               IDLE: begin
                  if (vb_start && !pause) begin
                     state      <= ISSUE;
                     busy       <= 1'b1;
                     task_idx   <= '0;
                     task_start <= N_TASKS'(1);
                  end
               end
               ISSUE: begin
                  state <= WAIT;
               end
               WAIT: begin
                  if (task_done[task_idx]) begin
                     if (task_idx == LAST_IDX) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        task_idx <= '0;
                     end else begin
                        state      <= ISSUE;
                        task_idx   <= task_idx + IW'(1);
                        task_start <= N_TASKS'(1) << (task_idx + IW'(1));
                     end
                  end
               end
               default: begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  task_idx <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: vector table, randomized frames against a
// timing model, hand-written reset/deadline/stall sequences and a compressed free run.
`timescale 1ns/1ps

module tb_frame_scheduler;

   logic       clk;
   logic       rst;
   logic [9:0] y;
   logic       pause;
   logic [3:0] task_done;
   logic [3:0] task_start;
   logic       busy;
   logic [1:0] task_idx;
   logic [15:0] frame_cnt;
   logic       overrun;
   logic [7:0] overrun_cnt;

   int errors;
   int checks;
   int exp_frames;
   int exp_ovr;

   typedef struct packed {
      bit         pe;
      bit         pm;
      int         d0;
      int         d1;
      int         d2;
      int         d3;
      logic [3:0] first;
      int         len;
   } vec_t;

   vec_t vecs [4];

   frame_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .y           (y),
      .pause       (pause),
      .task_done   (task_done),
      .task_start  (task_start),
      .busy        (busy),
      .task_idx    (task_idx),
      .frame_cnt   (frame_cnt),
      .overrun     (overrun),
      .overrun_cnt (overrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // A frame is counted by the model whenever y newly lands on the blanking line.
   task automatic setY(input logic [9:0] v);
      if (v == 10'd480 && y != 10'd480) exp_frames++;
      y = v;
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, " task_start"}, task_start, 4'b0000);
      checkOutput({tag, " busy"}, busy, 1'b0);
      checkOutput({tag, " task_idx"}, task_idx, 2'd0);
   endtask

   // Runs one blanking entry; task k returns done d_k cycles after its start.
   task automatic applyStimulus(input bit p_entry, input bit p_mid,
                                input int d0, input int d1, input int d2, input int d3,
                                input bit noise, output int busy_len, output logic [3:0] first_start);
      int d [4];
      int st [4];
      int endc;
      int last;
      int exp_idx;
      logic [3:0] exp_start;
      logic [3:0] nd;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      st[0] = 1;
      for (int k = 1; k < 4; k++) st[k] = st[k-1] + d[k-1] + 1;
      endc = p_entry ? 0 : st[3] + d[3] + 1;
      last = p_entry ? 6 : endc + 3;
      pause = p_entry;
      task_done = 4'b0000;
      setY(10'd479);
      step();
      step();
      setY(10'd480);
      busy_len = 0;
      first_start = 4'b0000;
      for (int c = 1; c <= last; c++) begin
         step();
         exp_start = 4'b0000;
         exp_idx = 0;
         if (c < endc) begin
            for (int k = 0; k < 4; k++) begin
               if (c >= st[k]) exp_idx = k;
               if (c == st[k]) exp_start[k] = 1'b1;
            end
         end
         checkOutput($sformatf("task_start c%0d", c), task_start, exp_start);
         checkOutput($sformatf("busy c%0d", c), busy, (c < endc));
         checkOutput($sformatf("task_idx c%0d", c), task_idx, exp_idx);
         checkOutput($sformatf("overrun c%0d", c), overrun, 1'b0);
         if (busy) busy_len++;
         if (task_start != 4'b0000 && first_start == 4'b0000) first_start = task_start;
         nd = noise ? 4'($urandom) : 4'b0000;
         if (c < endc) begin
            if (c != st[exp_idx]) nd[exp_idx] = 1'b0;
            if (c == st[exp_idx] + d[exp_idx]) nd[exp_idx] = 1'b1;
         end
         if (p_mid && c == 2) pause = 1'b1;
         task_done = nd;
      end
      task_done = 4'b0000;
      pause = 1'b0;
      checkOutput("frame_cnt after frame", frame_cnt, exp_frames);
      checkOutput("overrun_cnt after frame", overrun_cnt, exp_ovr);
   endtask

   // Starts a sequence whose task 2 never finishes.
   task automatic stallAtTask2();
      pause = 1'b0;
      task_done = 4'b0000;
      setY(10'd479);
      step();
      step();
      setY(10'd480);
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c == 1) checkOutput("stall start0", task_start, 4'b0001);
         if (c == 3) checkOutput("stall start1", task_start, 4'b0010);
         if (c == 6) checkOutput("stall start2", task_start, 4'b0100);
         task_done = (c == 2) ? 4'b0001 : (c == 5) ? 4'b0010 : 4'b0000;
      end
   endtask

   // Compressed raster with one-cycle task responders; line 490 marks a vsync falling edge.
   task automatic freeRun();
      int base;
      int falls;
      int starts;
      logic [3:0] resp;
      base = exp_frames;
      falls = 0;
      starts = 0;
      resp = 4'b0000;
      for (int f = 0; f < 3; f++) begin
         for (int line = 0; line < 525; line++) begin
            setY(10'(line));
            if (line == 490) falls++;
            for (int i = 0; i < 8; i++) begin
               step();
               task_done = resp;
               resp = task_start;
               if (task_start != 4'b0000) starts++;
            end
         end
      end
      task_done = 4'b0000;
      checkOutput("freerun frame_cnt", frame_cnt, exp_frames);
      checkOutput("freerun frames vs vsync", exp_frames - base, falls);
      checkOutput("freerun start count", starts, 4 * falls);
      checkOutput("freerun overrun_cnt", overrun_cnt, exp_ovr);
      checkOutput("freerun busy", busy, 1'b0);
   endtask

   initial begin
      #1000000;
      errors++;
      $display("[TB] FAIL timeout: simulation did not finish within 1 ms");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      int blen;
      logic [3:0] fst;
      int d [4];
      bit p;
      int len;
      errors = 0;
      checks = 0;
      exp_frames = 0;
      exp_ovr = 0;

      vecs[0] = '{pe: 1'b0, pm: 1'b0, d0: 5, d1: 5, d2: 5, d3: 5, first: 4'b0001, len: 24};
      vecs[1] = '{pe: 1'b1, pm: 1'b0, d0: 5, d1: 5, d2: 5, d3: 5, first: 4'b0000, len: 0};
      vecs[2] = '{pe: 1'b0, pm: 1'b1, d0: 1, d1: 1, d2: 1, d3: 1, first: 4'b0001, len: 8};
      vecs[3] = '{pe: 1'b0, pm: 1'b0, d0: 3, d1: 1, d2: 7, d3: 2, first: 4'b0001, len: 17};

      rst = 1'b0;
      y = 10'd479;
      pause = 1'b0;
      task_done = 4'b0000;
      #100;
      checkIdleOutputs("reset");
      checkOutput("reset frame_cnt", frame_cnt, 16'd0);
      checkOutput("reset overrun", overrun, 1'b0);
      checkOutput("reset overrun_cnt", overrun_cnt, 8'd0);
      rst = 1'b1;
      step();
      checkIdleOutputs("post-release");
      setY(10'd480);
      step();
      checkOutput("first start", task_start, 4'b0001);
      checkOutput("first frame_cnt", frame_cnt, 16'd1);
      checkOutput("first busy", busy, 1'b1);
      step();
      checkOutput("start one cycle", task_start, 4'b0000);
      #3;
      rst = 1'b0;
      exp_frames = 0;
      #1;
      checkIdleOutputs("async reset");
      checkOutput("async reset frame_cnt", frame_cnt, 16'd0);
      setY(10'd100);
      #2;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checkIdleOutputs("reset release");
      end

      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i].pe, vecs[i].pm, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3,
                       1'b0, blen, fst);
         checkOutput($sformatf("vec%0d first start", i), fst, vecs[i].first);
         checkOutput($sformatf("vec%0d busy len", i), blen, vecs[i].len);
      end

      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < 4; k++) d[k] = $urandom_range(1, 8);
         p = ($urandom_range(0, 3) == 0);
         len = p ? 0 : (d[0] + d[1] + d[2] + d[3] + 4);
         applyStimulus(p, 1'b0, d[0], d[1], d[2], d[3], 1'b1, blen, fst);
         checkOutput($sformatf("rand%0d busy len", i), blen, len);
      end

`ifdef FRAME_SCHED_WATCHDOG_EN
      stallAtTask2();
      setY(10'd520);
      step();
      exp_ovr++;
      checkOutput("deadline overrun", overrun, 1'b1);
      checkOutput("deadline overrun_cnt", overrun_cnt, exp_ovr);
      checkIdleOutputs("deadline");
      step();
      checkOutput("deadline pulse width", overrun, 1'b0);
      checkOutput("deadline no start", task_start, 4'b0000);
      applyStimulus(1'b0, 1'b0, 2, 2, 2, 2, 1'b0, blen, fst);
      checkOutput("after deadline first start", fst, 4'b0001);

      setY(10'd479);
      step();
      step();
      setY(10'd480);
      for (int c = 1; c <= 4; c++) begin
         step();
         if (c == 3) checkOutput("simul start1", task_start, 4'b0010);
         task_done = (c == 2) ? 4'b0001 : (c == 4) ? 4'b0010 : 4'b0000;
         if (c == 4) setY(10'd520);
      end
      step();
      task_done = 4'b0000;
      exp_ovr++;
      checkOutput("simul overrun", overrun, 1'b1);
      checkOutput("simul overrun_cnt", overrun_cnt, exp_ovr);
      checkIdleOutputs("simul abort");
      step();
      checkOutput("simul no start2", task_start, 4'b0000);
`else
      stallAtTask2();
      setY(10'd520);
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("stall busy", busy, 1'b1);
         checkOutput("stall task_idx", task_idx, 2'd2);
         checkOutput("stall overrun", overrun, 1'b0);
         checkOutput("stall overrun_cnt", overrun_cnt, 8'd0);
      end
      setY(10'd479);
      step();
      setY(10'd480);
      step();
      checkOutput("busy vb frame_cnt", frame_cnt, exp_frames);
      checkOutput("busy vb no start", task_start, 4'b0000);
      checkOutput("busy vb task_idx", task_idx, 2'd2);
      task_done = 4'b0100;
      step();
      task_done = 4'b0000;
      checkOutput("resume start3", task_start, 4'b1000);
      checkOutput("resume task_idx", task_idx, 2'd3);
      step();
      task_done = 4'b1000;
      step();
      task_done = 4'b0000;
      checkIdleOutputs("resume done");
`endif

      freeRun();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
